// File: rtl/dpram_be_clr.sv
// True dual-port RAM with byte enables, selectable read latency and a hardware clear engine.
// Optional same-address conflict detection: define DPRAM_COLLISION_DET_EN.
module dpram_be_clr #(
  parameter int unsigned         DATA_W     = 16,
  parameter int unsigned         ADDR_W     = 13,
  parameter int unsigned         DEPTH      = 4800,
  parameter int unsigned         READ_LAT   = 1,
  parameter int unsigned         WRITE_MODE = 0,
  parameter logic [DATA_W-1:0]   CLR_VALUE  = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clr,
  output logic                   o_busy,
  input  logic                   i_ce0,
  input  logic                   i_ce1,
  input  logic [DATA_W/8-1:0]    i_we0,
  input  logic [DATA_W/8-1:0]    i_we1,
  input  logic [ADDR_W-1:0]      i_addr0,
  input  logic [ADDR_W-1:0]      i_addr1,
  input  logic [DATA_W-1:0]      i_byte0,
  input  logic [DATA_W-1:0]      i_byte1,
  output logic [DATA_W-1:0]      o_byte0,
  output logic [DATA_W-1:0]      o_byte1,
  output logic                   o_valid0,
  output logic                   o_valid1,
  output logic                   o_collision
);

  localparam int unsigned NB = DATA_W / 8;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
  logic                r_busy, w_busy_nxt, w_clr_wr;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_ce    [2];
  logic [NB-1:0]       w_we    [2];
  logic [ADDR_W-1:0]   w_addr  [2];
  logic [DATA_W-1:0]   w_din   [2];
  logic                w_inr   [2];
  logic                w_acc   [2];
  logic [DATA_W-1:0]   w_old   [2];
  logic [DATA_W-1:0]   w_merge [2];
  logic [DATA_W-1:0]   w_rdata [2];
  logic                w_fin_v [2];
  logic [DATA_W-1:0]   w_fin_d [2];
  logic                r_vld   [2];
  logic [DATA_W-1:0]   r_dout  [2];

  assign w_ce[0]   = i_ce0;
  assign w_ce[1]   = i_ce1;
  assign w_we[0]   = i_we0;
  assign w_we[1]   = i_we1;
  assign w_addr[0] = i_addr0;
  assign w_addr[1] = i_addr1;
  assign w_din[0]  = i_byte0;
  assign w_din[1]  = i_byte1;

  // Clear-engine state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Clear-engine next state; busy drops on the edge that writes DEPTH-1
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_wr    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_wr  = 1'b1;
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      S_IDLE: begin
        if (i_clr) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
    w_busy_nxt = (w_state_nxt == S_CLEAR);
  end

  // Per-port read word; a port only ever merges its own write data
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_inr[p]   = (32'(w_addr[p]) < DEPTH);
      w_acc[p]   = w_ce[p] & ~r_busy;
      w_old[p]   = w_inr[p] ? r_mem[w_addr[p]] : '0;
      w_merge[p] = w_old[p];
      for (int k = 0; k < int'(NB); k++) begin
        if (w_we[p][k]) w_merge[p][8*k +: 8] = w_din[p][8*k +: 8];
      end
      w_rdata[p] = (WRITE_MODE == 1) ? w_merge[p] : w_old[p];
    end
  end

  // Array write; port 0 is applied last so it wins shared lanes
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_clr_wr) begin
        r_mem[r_cnt] <= CLR_VALUE;
      end else if (r_state == S_IDLE) begin
        for (int p = 1; p >= 0; p--) begin
          for (int k = 0; k < int'(NB); k++) begin
            if (w_ce[p] && w_inr[p] && w_we[p][k])
              r_mem[w_addr[p]][8*k +: 8] <= w_din[p][8*k +: 8];
          end
        end
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              r_s1_v [2];
      logic [DATA_W-1:0] r_s1_d [2];
      always_ff @(posedge i_clk) begin
        for (int p = 0; p < 2; p++) begin
          if (i_rst) begin
            r_s1_v[p] <= 1'b0;
            r_s1_d[p] <= '0;
          end else begin
            r_s1_v[p] <= w_acc[p];
            if (w_acc[p]) r_s1_d[p] <= w_rdata[p];
          end
        end
      end
      always_comb begin
        for (int p = 0; p < 2; p++) begin
          w_fin_v[p] = r_s1_v[p];
          w_fin_d[p] = r_s1_d[p];
        end
      end
    end else begin : g_lat1
      always_comb begin
        for (int p = 0; p < 2; p++) begin
          w_fin_v[p] = w_acc[p];
          w_fin_d[p] = w_rdata[p];
        end
      end
    end
  endgenerate

  // Output stage; results landing while the clear engine runs are dropped
  always_ff @(posedge i_clk) begin
    for (int p = 0; p < 2; p++) begin
      if (i_rst) begin
        r_vld[p]  <= 1'b0;
        r_dout[p] <= '0;
      end else begin
        r_vld[p] <= w_fin_v[p] & ~w_busy_nxt;
        if (w_fin_v[p] && !w_busy_nxt) r_dout[p] <= w_fin_d[p];
      end
    end
  end

`ifdef DPRAM_COLLISION_DET_EN
  logic r_coll;
  logic w_conf;
  assign w_conf = w_acc[0] & w_acc[1] & w_inr[0] & (w_addr[0] == w_addr[1]) &
                  ((|w_we[0]) | (|w_we[1]));
  always_ff @(posedge i_clk) begin
    if (i_rst) r_coll <= 1'b0;
    else       r_coll <= w_conf;
  end
  assign o_collision = r_coll;
`else
  assign o_collision = 1'b0;
`endif

  assign o_busy   = r_busy;
  assign o_byte0  = r_dout[0];
  assign o_byte1  = r_dout[1];
  assign o_valid0 = r_vld[0];
  assign o_valid1 = r_vld[1];

endmodule

// File: tb/tb_dpram_be_clr.sv
// Directed bench: instance A uses defaults, instance B uses READ_LAT=2, WRITE_MODE=1, CLR_VALUE=A5A5.
module tb_dpram_be_clr;

  logic        clk = 1'b0;
  logic        rst, clr, ce0, ce1;
  logic [1:0]  we0, we1;
  logic [12:0] a0, a1;
  logic [15:0] d0, d1;

  logic        a_busy, a_v0, a_v1, a_col;
  logic [15:0] a_b0, a_b1;
  logic        b_busy, b_v0, b_v1, b_col;
  logic [15:0] b_b0, b_b1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n;
  logic seen;

`ifdef DPRAM_COLLISION_DET_EN
  localparam logic COL = 1'b1;
`else
  localparam logic COL = 1'b0;
`endif

  dpram_be_clr u_a (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .o_busy(a_busy),
    .i_ce0(ce0), .i_ce1(ce1), .i_we0(we0), .i_we1(we1),
    .i_addr0(a0), .i_addr1(a1), .i_byte0(d0), .i_byte1(d1),
    .o_byte0(a_b0), .o_byte1(a_b1), .o_valid0(a_v0), .o_valid1(a_v1),
    .o_collision(a_col)
  );

  dpram_be_clr #(.READ_LAT(2), .WRITE_MODE(1), .CLR_VALUE(16'hA5A5)) u_b (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .o_busy(b_busy),
    .i_ce0(ce0), .i_ce1(ce1), .i_we0(we0), .i_we1(we1),
    .i_addr0(a0), .i_addr1(a1), .i_byte0(d0), .i_byte1(d1),
    .o_byte0(b_b0), .o_byte1(b_b1), .o_valid0(b_v0), .o_valid1(b_v1),
    .o_collision(b_col)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ce0 = 1'b0; ce1 = 1'b0; we0 = 2'b00; we1 = 2'b00; clr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; idle_in(); a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    tick();
    chk("rst_busy",  32'(a_busy), 1);
    chk("rst_v0",    32'(a_v0),   0);
    chk("rst_byte0", 32'(a_b0),   0);
    chk("rst_col",   32'(a_col),  0);
    chk("rst_b_v1",  32'(b_v1),   0);
    rst = 1'b0;
    n = 0;
    while (a_busy && n < 10000) begin n++; tick(); end
    chk("clr_len", 32'(n), 4800);
    chk("b_busy_end", 32'(b_busy), 0);

    // reads of cleared words, back to back
    ce0 = 1'b1; a0 = 13'd0; tick();
    chk("rd0_a_v", 32'(a_v0), 1); chk("rd0_a_d", 32'(a_b0), 'h0000); chk("rd0_b_v", 32'(b_v0), 0);
    a0 = 13'd2399; tick();
    chk("rd2399_a_d", 32'(a_b0), 'h0000); chk("rd0_b_v2", 32'(b_v0), 1); chk("rd0_b_d", 32'(b_b0), 'hA5A5);
    a0 = 13'd4799; tick();
    chk("rd4799_a_v", 32'(a_v0), 1); chk("rd4799_a_d", 32'(a_b0), 'h0000);
    ce0 = 1'b0; tick();
    chk("rd_end_a_v", 32'(a_v0), 0); chk("rd4799_b_v", 32'(b_v0), 1); chk("rd4799_b_d", 32'(b_b0), 'hA5A5);
    tick();
    chk("rd_end_b_v", 32'(b_v0), 0);

    // preload 1..3 via port 1, read back via port 0
    ce1 = 1'b1; we1 = 2'b11; a1 = 13'd1; d1 = 16'h0011; tick();
    a1 = 13'd2; d1 = 16'h0022; tick();
    a1 = 13'd3; d1 = 16'h0033; tick();
    idle_in();
    ce0 = 1'b1; a0 = 13'd1; tick();
    chk("lat_a1", 32'(a_b0), 'h0011); chk("lat_b_v_early", 32'(b_v0), 0);
    a0 = 13'd2; tick();
    chk("lat_a2", 32'(a_b0), 'h0022); chk("lat_b_v1", 32'(b_v0), 1); chk("lat_b1", 32'(b_b0), 'h0011);
    a0 = 13'd3; tick();
    chk("lat_a3", 32'(a_b0), 'h0033); chk("lat_b2", 32'(b_b0), 'h0022);
    ce0 = 1'b0; tick();
    chk("lat_a_v_off", 32'(a_v0), 0); chk("lat_a_hold", 32'(a_b0), 'h0033);
    chk("lat_b_v3", 32'(b_v0), 1); chk("lat_b3", 32'(b_b0), 'h0033);
    tick();
    chk("lat_b_v_off", 32'(b_v0), 0);

    // byte enables
    ce0 = 1'b1; we0 = 2'b11; a0 = 13'd5; d0 = 16'hABCD; tick();
    we0 = 2'b01; d0 = 16'h1234; tick();
    chk("be_a_old", 32'(a_b0), 'hABCD);
    we0 = 2'b00; tick();
    chk("be_a_rd", 32'(a_b0), 'hAB34); chk("be_b_wf", 32'(b_b0), 'hAB34);
    ce0 = 1'b0; tick();
    chk("be_b_rd", 32'(b_b0), 'hAB34); chk("be_b_v", 32'(b_v0), 1);

    // read-during-write mode
    ce0 = 1'b1; we0 = 2'b11; a0 = 13'd7; d0 = 16'h0F0F; tick();
    d0 = 16'hF0F0; tick();
    chk("wm0_a", 32'(a_b0), 'h0F0F);
    idle_in(); tick();
    chk("wm1_b", 32'(b_b0), 'hF0F0); chk("wm_a_v_off", 32'(a_v0), 0);

    // cross-port write/write
    ce0 = 1'b1; we0 = 2'b01; a0 = 13'd10; d0 = 16'h1111;
    ce1 = 1'b1; we1 = 2'b11; a1 = 13'd10; d1 = 16'h2222; tick();
    chk("ww_col_a", 32'(a_col), 32'(COL)); chk("ww_col_b", 32'(b_col), 32'(COL));
    chk("ww_a_old", 32'(a_b0), 'h0000);
    idle_in(); tick();
    chk("ww_col_off", 32'(a_col), 0);
    ce1 = 1'b1; a1 = 13'd10; tick();
    chk("ww_mem_v", 32'(a_v1), 1); chk("ww_mem", 32'(a_b1), 'h2211);
    ce0 = 1'b1; a0 = 13'd10; tick();
    chk("rr_a0", 32'(a_b0), 'h2211); chk("rr_a1", 32'(a_b1), 'h2211); chk("rr_col", 32'(a_col), 0);

    // read on port 0 while port 1 writes the same word
    we1 = 2'b11; d1 = 16'h3333; tick();
    chk("rw_a_old", 32'(a_b0), 'h2211); chk("rw_col", 32'(a_col), 32'(COL));
    idle_in(); tick();
    chk("rw_b_old", 32'(b_b0), 'h2211);
    ce0 = 1'b1; a0 = 13'd10; tick();
    chk("rw_a_new", 32'(a_b0), 'h3333);
    idle_in();

    // clear request, accesses ignored while busy, reset mid-clear
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("clr_busy", 32'(a_busy), 1);
    ce0 = 1'b1; we0 = 2'b11; a0 = 13'd20; d0 = 16'h5555;
    seen = 1'b0;
    repeat (99) begin tick(); if (a_v0 !== 1'b0) seen = 1'b1; end
    we0 = 2'b00; a0 = 13'd0;
    rst = 1'b1; tick();
    rst = 1'b0;
    n = 0;
    while (a_busy && n < 10000) begin
      if (a_v0 !== 1'b0 || b_v0 !== 1'b0) seen = 1'b1;
      n++; tick();
    end
    chk("clr_len2", 32'(n), 4800);
    chk("busy_no_valid", 32'(seen), 0);
    a0 = 13'd5000; tick();
    chk("oor_a_v", 32'(a_v0), 1); chk("oor_a_d", 32'(a_b0), 'h0000);
    a0 = 13'd5; tick();
    chk("clr5_a", 32'(a_b0), 'h0000); chk("oor_b_v", 32'(b_v0), 1); chk("oor_b_d", 32'(b_b0), 'h0000);
    ce0 = 1'b0; tick();
    chk("clr5_b", 32'(b_b0), 'hA5A5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
